// File: rtl/adder_share_arbiter_pkg.sv
// adder_share_pkg: shared definitions for the adder-sharing arbiter.
//   - FSM state encodings (IDLE / EXEC / RESP)
//   - default datapath / requester-count constants
//   - signed-overflow helper used when registering the adder result
package adder_share_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ID_W    = 2;
  localparam int DEF_CNT_W   = 16;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Two's-complement overflow: operands share a sign and the sum does not.
  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_share_arbiter_if.sv
// adder_share_if: request and response channels of the adder-sharing arbiter.
//
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where VALID and READY are both high. The producer keeps VALID and its data
// stable until that edge; READY may depend combinationally on VALID.
//
// Signals:
//   REQ_VALID [NUM_REQ]        per-requester request valid   (master -> slave)
//   REQ_READY [NUM_REQ]        per-requester accept, one-hot or zero (slave -> master)
//   REQ_A/REQ_B [NUM_REQ*WIDTH] flattened operands, slice i is requester i
//   RSP_VALID / RSP_READY      shared response handshake
//   RSP_ID, RSP_SUM, RSP_COUT, RSP_OVF  response payload, qualified by RSP_VALID
interface adder_share_if
  import adder_share_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = DEF_ID_W
);

  logic [NUM_REQ-1:0]       REQ_VALID;
  logic [NUM_REQ-1:0]       REQ_READY;
  logic [NUM_REQ*WIDTH-1:0] REQ_A;
  logic [NUM_REQ*WIDTH-1:0] REQ_B;
  logic                     RSP_VALID;
  logic                     RSP_READY;
  logic [ID_W-1:0]          RSP_ID;
  logic [WIDTH-1:0]         RSP_SUM;
  logic                     RSP_COUT;
  logic                     RSP_OVF;

  // Client side: issues requests, consumes responses.
  modport master (
    output REQ_VALID, REQ_A, REQ_B, RSP_READY,
    input  REQ_READY, RSP_VALID, RSP_ID, RSP_SUM, RSP_COUT, RSP_OVF
  );

  // Arbiter side.
  modport slave (
    input  REQ_VALID, REQ_A, REQ_B, RSP_READY,
    output REQ_READY, RSP_VALID, RSP_ID, RSP_SUM, RSP_COUT, RSP_OVF
  );

endinterface

// File: rtl/adder_share_arbiter_adder.sv
// n_bit_full_adder_top: combinational WIDTH-bit ripple-carry adder.
//
// Ports:
//   a_i, b_i [WIDTH]  operands
//   cin_i             carry in
//   sum_o [WIDTH]     a_i + b_i + cin_i, modulo 2^WIDTH
//   cout_o            carry out of the top bit
module n_bit_full_adder_top #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = carry[WIDTH];

endmodule

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: shares one ripple adder between NUM_REQ requesters.
//
// Requests are arbitrated round-robin in IDLE; the winner's operands are
// latched, added in EXEC, and returned as a tagged response held in RESP
// until the consumer accepts it. One operation is in flight at a time.
//
// Ports:
//   CLK        clock, rising edge
//   RST_N      synchronous active-low reset
//   bus        adder_share_if slave modport (request and response channels)
//   BUSY       high whenever the FSM is not in IDLE
//   OP_COUNT   completed responses, wraps modulo 2^CNT_W
//   DBG_STATE  current FSM state (IDLE/EXEC/RESP encodings from the package)
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = DEF_ID_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST_N,
  adder_share_if.slave     bus,
  output logic             BUSY,
  output logic [CNT_W-1:0] OP_COUNT,
  output logic [1:0]       DBG_STATE
);

  logic [1:0]       state_q,    state_d;
  logic [ID_W-1:0]  ptr_q,      ptr_d;
  logic [WIDTH-1:0] a_q,        a_d;
  logic [WIDTH-1:0] b_q,        b_d;
  logic [ID_W-1:0]  id_q,       id_d;
  logic [ID_W-1:0]  rsp_id_q,   rsp_id_d;
  logic [WIDTH-1:0] rsp_sum_q,  rsp_sum_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             rsp_ovf_q,  rsp_ovf_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  logic               grant_found;
  logic [ID_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0] req_ready;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic [WIDTH:0]     add_full;

  // Shared datapath: always fed from the latched operands, so its output is
  // settled by the end of EXEC regardless of what the requesters do.
  n_bit_full_adder_top #(.WIDTH(WIDTH)) u_adder (
    .a_i    (a_q),
    .b_i    (b_q),
    .cin_i  (1'b0),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  assign add_full = {add_cout, add_sum};

  // Round-robin select: first asserted valid at or after the pointer,
  // scanning upward and wrapping at NUM_REQ.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!grant_found && bus.REQ_VALID[idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

  // Ready is offered only to the current winner, and only while idle and
  // out of reset.
  always_comb begin
    req_ready = '0;
    if (RST_N && (state_q == IDLE) && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    rsp_id_d   = rsp_id_q;
    rsp_sum_d  = rsp_sum_q;
    rsp_cout_d = rsp_cout_q;
    rsp_ovf_d  = rsp_ovf_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        // A found grant always has valid high and ready high: transfer.
        if (grant_found) begin
          a_d     = bus.REQ_A[int'(grant_idx) * WIDTH +: WIDTH];
          b_d     = bus.REQ_B[int'(grant_idx) * WIDTH +: WIDTH];
          id_d    = grant_idx;
          ptr_d   = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_id_d   = id_q;
        rsp_sum_d  = add_full[WIDTH-1:0];
        rsp_cout_d = add_full[WIDTH];
        rsp_ovf_d  = signed_ovf(a_q[WIDTH-1], b_q[WIDTH-1], add_full[WIDTH-1]);
        state_d    = RESP;
      end
      RESP: begin
        if (bus.RSP_READY) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
      rsp_id_q   <= '0;
      rsp_sum_q  <= '0;
      rsp_cout_q <= 1'b0;
      rsp_ovf_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      a_q        <= a_d;
      b_q        <= b_d;
      id_q       <= id_d;
      rsp_id_q   <= rsp_id_d;
      rsp_sum_q  <= rsp_sum_d;
      rsp_cout_q <= rsp_cout_d;
      rsp_ovf_q  <= rsp_ovf_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.REQ_READY = req_ready;
  assign bus.RSP_VALID = (state_q == RESP);
  assign bus.RSP_ID    = rsp_id_q;
  assign bus.RSP_SUM   = rsp_sum_q;
  assign bus.RSP_COUT  = rsp_cout_q;
  assign bus.RSP_OVF   = rsp_ovf_q;
  assign BUSY          = (state_q != IDLE);
  assign OP_COUNT      = cnt_q;
  assign DBG_STATE     = state_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: directed vectors with
// hand-computed results pushed into an expected queue, popped by a monitor
// on every response handshake.
module tb_adder_share_arbiter;
  import adder_share_pkg::*;

  localparam int WIDTH   = 32;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 16;
  localparam int EW      = ID_W + 2 + WIDTH;  // {id, cout, ovf, sum}

  logic             CLK;
  logic             RST_N;
  logic             BUSY;
  logic [CNT_W-1:0] OP_COUNT;
  logic [1:0]       DBG_STATE;

  adder_share_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  adder_share_arbiter #(
    .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .bus       (bus),
    .BUSY      (BUSY),
    .OP_COUNT  (OP_COUNT),
    .DBG_STATE (DBG_STATE)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time exceeded, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0]    exp_q[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  int               errors  = 0;
  int               checks  = 0;
  int               acc_cyc = 0;
  logic             prev_valid = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push_exp(input int id, input logic [WIDTH-1:0] sum,
                          input logic cout, input logic ovf);
    exp_q.push_back({ID_W'(id), cout, ovf, sum});
  endtask

  // Inputs only change 1 time unit after a rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic issue(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bit got;
    got = 1'b0;
    bus.REQ_A[id*WIDTH +: WIDTH] = a;
    bus.REQ_B[id*WIDTH +: WIDTH] = b;
    bus.REQ_VALID[id] = 1'b1;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge CLK);
      if (bus.REQ_READY[id]) begin
        got     = 1'b1;
        acc_cyc = cyc;
      end
    end
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL grant_timeout: requester %0d got no ready, expected ready within 300 cycles", id);
    end
    step();
    bus.REQ_VALID[id] = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(negedge CLK);
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    step();
    step();
    RST_N   = 1'b1;
    exp_cnt = '0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    logic [EW-1:0] e;
    if (RST_N) begin
      if (bus.RSP_VALID && !prev_valid)
        chk("accept_to_valid_latency", 64'(cyc - acc_cyc), 64'd2);
      if (bus.RSP_VALID && bus.RSP_READY) begin
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_rsp: got id=%0d sum=%0d, expected no response",
                   bus.RSP_ID, bus.RSP_SUM);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id",   64'(bus.RSP_ID),   64'(e[EW-1 -: ID_W]));
          chk("rsp_sum",  64'(bus.RSP_SUM),  64'(e[WIDTH-1:0]));
          chk("rsp_cout", 64'(bus.RSP_COUT), 64'(e[WIDTH+1]));
          chk("rsp_ovf",  64'(bus.RSP_OVF),  64'(e[WIDTH]));
          chk("op_count_at_rsp", 64'(OP_COUNT), 64'(exp_cnt));
          exp_cnt++;
        end
      end
    end
    prev_valid = bus.RSP_VALID;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [CNT_W-1:0] cnt_before;
    bit               seen;
    RST_N         = 1'b0;
    bus.REQ_VALID = '0;
    bus.REQ_A     = '0;
    bus.REQ_B     = '0;
    bus.RSP_READY = 1'b1;
    step();
    step();
    RST_N = 1'b1;
    @(negedge CLK);

    // Reset state
    chk("reset_rsp_valid", 64'(bus.RSP_VALID), 64'd0);
    chk("reset_rsp_id",    64'(bus.RSP_ID),    64'd0);
    chk("reset_rsp_sum",   64'(bus.RSP_SUM),   64'd0);
    chk("reset_rsp_cout",  64'(bus.RSP_COUT),  64'd0);
    chk("reset_rsp_ovf",   64'(bus.RSP_OVF),   64'd0);
    chk("reset_busy",      64'(BUSY),          64'd0);
    chk("reset_op_count",  64'(OP_COUNT),      64'd0);
    chk("reset_req_ready", 64'(bus.REQ_READY), 64'd0);
    chk("reset_state",     64'(DBG_STATE),     64'(IDLE));
    step();

    // Single request on requester 1
    push_exp(1, 32'd5774, 1'b0, 1'b0);
    issue(1, 32'd1209, 32'd4565);
    wait_drain();
    chk("op_count_after_first", 64'(OP_COUNT), 64'd1);
    step();

    // Carry-out and signed overflow boundaries on requester 0
    push_exp(0, 32'd0, 1'b1, 1'b0);
    issue(0, 32'd4294967295, 32'd1);
    push_exp(0, 32'd2147483648, 1'b0, 1'b1);
    issue(0, 32'd2147483647, 32'd1);
    push_exp(0, 32'd0, 1'b1, 1'b1);
    issue(0, 32'h8000_0000, 32'h8000_0000);
    wait_drain();
    step();

    // All four requesting from reset: grant order 0,1,2,3
    do_reset();
    push_exp(0, 32'd100, 1'b0, 1'b0);
    push_exp(1, 32'd101, 1'b0, 1'b0);
    push_exp(2, 32'd102, 1'b0, 1'b0);
    push_exp(3, 32'd103, 1'b0, 1'b0);
    fork
      issue(0, 32'd0, 32'd100);
      issue(1, 32'd1, 32'd100);
      issue(2, 32'd2, 32'd100);
      issue(3, 32'd3, 32'd100);
    join
    wait_drain();
    chk("op_count_after_round", 64'(OP_COUNT), 64'd4);
    step();

    // Pointer back at 0: requesters 3 and 0 together -> 0 first, then 3
    push_exp(0, 32'd100, 1'b0, 1'b0);
    push_exp(3, 32'd15, 1'b0, 1'b0);
    fork
      issue(0, 32'd50, 32'd50);
      issue(3, 32'd7, 32'd8);
    join
    wait_drain();
    step();

    // Backpressure: hold response for 10 cycles with another request pending
    bus.RSP_READY = 1'b0;
    push_exp(2, 32'd12, 1'b0, 1'b0);
    issue(2, 32'd5, 32'd7);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge CLK);
      seen = bus.RSP_VALID;
    end
    chk("bp_rsp_valid_seen", 64'(seen), 64'd1);
    cnt_before = OP_COUNT;
    step();
    push_exp(1, 32'd30, 1'b0, 1'b0);
    fork
      issue(1, 32'd10, 32'd20);
    join_none
    for (int n = 0; n < 10; n++) begin
      @(negedge CLK);
      chk("bp_rsp_valid", 64'(bus.RSP_VALID), 64'd1);
      chk("bp_rsp_id",    64'(bus.RSP_ID),    64'd2);
      chk("bp_rsp_sum",   64'(bus.RSP_SUM),   64'd12);
      chk("bp_req_ready", 64'(bus.REQ_READY), 64'd0);
      chk("bp_op_count",  64'(OP_COUNT),      64'(cnt_before));
      chk("bp_busy",      64'(BUSY),          64'd1);
    end
    step();
    bus.RSP_READY = 1'b1;
    @(negedge CLK);  // response handshake
    @(negedge CLK);  // back in IDLE
    chk("bp_release_op_count", 64'(OP_COUNT),      64'(cnt_before + 1'b1));
    chk("bp_release_valid",    64'(bus.RSP_VALID), 64'd0);
    chk("bp_release_id_held",  64'(bus.RSP_ID),    64'd2);
    wait fork;
    wait_drain();
    chk("bp_final_op_count", 64'(OP_COUNT), 64'(cnt_before + 2'd2));
    step();

    // Reset during EXEC discards the operation
    issue(3, 32'd9, 32'd9);
    chk("mid_state_exec", 64'(DBG_STATE), 64'(EXEC));
    RST_N = 1'b0;
    step();
    RST_N   = 1'b1;
    exp_cnt = '0;
    @(negedge CLK);
    chk("mid_rst_valid", 64'(bus.RSP_VALID), 64'd0);
    chk("mid_rst_busy",  64'(BUSY),          64'd0);
    chk("mid_rst_count", 64'(OP_COUNT),      64'd0);
    chk("mid_rst_sum",   64'(bus.RSP_SUM),   64'd0);
    chk("mid_rst_state", 64'(DBG_STATE),     64'(IDLE));
    for (int n = 0; n < 6; n++) @(negedge CLK);
    step();
    push_exp(0, 32'd20, 1'b0, 1'b0);
    issue(0, 32'd17, 32'd3);
    wait_drain();
    chk("post_rst_op_count", 64'(OP_COUNT), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one instance of the existing N-bit ripple adder between NUM_REQ independent requesters.
- Each requester uses a valid/ready handshake. The block arbitrates round-robin, latches the winner's operands, runs the add, and returns a tagged response on a single shared response channel.
- Sits between client blocks and the combinational adder. Its job is sequencing and access control of that datapath.

Parameters:
- WIDTH, 32, operand and sum width in bits.
- NUM_REQ, 4, number of requesters; legal range 2 to 8.
- ID_W, 2, width of requester index; must equal clog2(NUM_REQ).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST_N  in  1  reset; synchronous, active-low.
- REQ_VALID  in  NUM_REQ  per-requester request valid.
- REQ_READY  out  NUM_REQ  per-requester accept; one-hot or zero.
- REQ_A  in  NUM_REQ*WIDTH  flattened operand A; slice i belongs to requester i.
- REQ_B  in  NUM_REQ*WIDTH  flattened operand B.
- RSP_VALID  out  1  response valid.
- RSP_READY  in  1  response consumer ready.
- RSP_ID  out  ID_W  index of the requester this response belongs to.
- RSP_SUM  out  WIDTH  A+B modulo 2^WIDTH.
- RSP_COUT  out  1  unsigned carry-out.
- RSP_OVF  out  1  signed overflow (both operands same sign, sum sign differs).
- BUSY  out  1  high in any state other than IDLE.
- OP_COUNT  out  CNT_W  completed responses; wraps modulo 2^CNT_W.

Behaviour:
- Reset (RST_N low at a rising edge):
  - state goes to IDLE and the round-robin pointer goes to 0.
  - RSP_VALID=0, RSP_ID=0, RSP_SUM=0, RSP_COUT=0, RSP_OVF=0, BUSY=0, OP_COUNT=0, REQ_READY=0.
  - Reset overrides every state; an in-flight operation is discarded with no response.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Grant g is the first asserted REQ_VALID at or after the pointer, searching upward with wrap.
  - REQ_READY[g]=1 combinationally; all other bits are 0. No valid request means REQ_READY=0.
  - A transfer occurs when REQ_VALID[g]&REQ_READY[g]. At that edge REQ_A/REQ_B slice g and the ID are latched, the pointer becomes (g+1) mod NUM_REQ, and the state goes to EXEC.
- EXEC:
  - REQ_READY=0.
  - The latched operands drive the adder sub-module.
  - At the edge, the sum, carry-out and overflow are registered into the RSP_* outputs and the state goes to RESP.
- RESP:
  - RSP_VALID=1. RSP_* outputs are stable until the handshake completes.
  - On RSP_VALID&RSP_READY: OP_COUNT increments, RSP_VALID drops next cycle, and the state returns to IDLE.
  - RSP_READY low holds RESP indefinitely (backpressure). No new request is accepted while in RESP.
- Latency and throughput:
  - Acceptance edge to RSP_VALID high is 2 cycles.
  - Minimum cycle is 3 clocks per operation (IDLE, EXEC, RESP).
- RSP_ID/SUM/COUT/OVF keep their last value after the handshake; only RSP_VALID qualifies them.
- A requester deasserting REQ_VALID before grant is legal; it is simply not granted. After acceptance, the operand inputs are don't-care.
- Simultaneous requests: only the round-robin winner is accepted. Losers keep REQ_VALID high and win in later rounds in pointer order. Starvation bound is NUM_REQ operations.
- Arithmetic: the full WIDTH+1 result comes from the adder. COUT=bit WIDTH. OVF=(A[W-1]==B[W-1])&&(SUM[W-1]!=A[W-1]).
- OP_COUNT wraps from 2^CNT_W-1 to 0 with no flag.

Decomposition:
- Shared package adder_share_pkg:
  - state enum (IDLE=2'd0, EXEC=2'd1, RESP=2'd2).
  - default WIDTH/NUM_REQ constants.
  - a function computing the signed overflow bit.
- Sub-module: the existing n_bit_full_adder_top, instantiated once with #(WIDTH) as the datapath. The carry is taken from a WIDTH+1 extension in the wrapper.
- Round-robin priority select is local combinational logic, not a separate module.

Test Plan:
- Single request, requester 1: A=1209, B=4565, RSP_READY=1 -> RSP_VALID 2 cycles after accept; RSP_ID=1, RSP_SUM=5774, COUT=0, OVF=0; OP_COUNT=1.
- Requester 0: A=4294967295, B=1 -> SUM=0, COUT=1, OVF=0. Then A=2147483647, B=1 -> SUM=2147483648, COUT=0, OVF=1.
- All four REQ_VALID high from reset, operands A=i, B=100 -> responses in ID order 0,1,2,3 with SUM 100,101,102,103; then the pointer is back at 0.
- Backpressure: hold RSP_READY=0 for 10 cycles in RESP -> RSP_* stable, REQ_READY=0 throughout, OP_COUNT unchanged. Release -> one handshake, OP_COUNT +1.
- Reset mid-operation: pull RST_N low during EXEC -> next edge gives IDLE, RSP_VALID=0, OP_COUNT=0, no response. A new request A=17, B=3 afterwards gives SUM=20, ID matching the requester.
